sprite_reg_queue: RTL and testbench
===================================

Name: sprite_reg_queue

Overview:
- Sits directly upstream of the sprite engine's register port (reg_wr/reg_addr/reg_data).
- Buffers CPU writes to sprite position/look registers in a FIFO.
- Drains the FIFO only during vertical blank, or at any time in immediate mode, so sprite state never changes mid-frame and sprites do not tear.
- Provides a one-write-per-cycle output stream, back-pressure to the CPU and a sticky overflow flag.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2.
- AW, 4, log2(DEPTH); FIFO pointer width.

Ports:
- clk_pixel  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- v_valid  input  1  high during visible lines, low during vertical blank; same signal the sprite engine uses.
- immediate  input  1  1 = drain regardless of v_valid.
- cpu_wr  input  1  write strobe, one entry per high cycle.
- cpu_addr  input  8  sprite register byte address, passed through unchanged.
- cpu_data  input  16  register data.
- cpu_ready  output  1  high when the FIFO is not full.
- ovf  output  1  sticky: a write was dropped.
- ovf_clr  input  1  clears ovf.
- level  output  AW+1  current FIFO occupancy, 0..DEPTH.
- reg_wr  output  1  one-cycle pulse per drained entry.
- reg_addr  output  8  address of the drained entry.
- reg_data  output  16  data of the drained entry.

Behaviour:
- Reset (async assert, sync release):
  - Pointers and level = 0, FIFO empty.
  - cpu_ready = 1, ovf = 0, reg_wr = 0, reg_addr = 0, reg_data = 0.
  - state = HOLD; v_valid_q = 1.
  - Reset during a drain discards all queued entries; no further reg_wr.
- FIFO:
  - Circular buffer of {addr[7:0], data[15:0]}; AW-bit pointers plus a separate level counter.
  - Full when level == DEPTH; empty when level == 0.
- Push: cpu_wr && !full stores the entry and increments wr_ptr (wraps DEPTH-1 -> 0).
- Drop:
  - cpu_wr && full: entry discarded, ovf <= 1 on the next edge.
  - Exception: if a pop occurs in the same cycle, the write is accepted instead (level stays DEPTH).
- Pop:
  - Entry is read from rd_ptr; reg_addr/reg_data are registered, reg_wr <= 1 on the same edge.
  - rd_ptr increments with wrap.
  - At most one pop per cycle.
- Simultaneous push and pop: level is unchanged. When empty, the push is stored and the pop is not performed that cycle (no fall-through).
- cpu_ready = (level != DEPTH), combinational from the level register.
- ovf_clr and a drop in the same cycle: ovf stays 1 (set wins).
- v_valid is registered once (v_valid_q). The drain window is open when (!v_valid_q || immediate).
- State machine, 2 states:
  - HOLD: no pops; reg_wr <= 0. Moves to DRAIN when the window opens and the FIFO is not empty.
  - DRAIN: pops one entry per cycle while the window is open and the FIFO is not empty. Returns to HOLD when the FIFO becomes empty or the window closes.
  - A pop already registered when the window closes still completes its reg_wr pulse. No pop is issued on the cycle after v_valid_q rises.
- Latency, window open and FIFO empty:
  - cpu_wr at edge N.
  - State enters DRAIN at edge N+1.
  - reg_wr high in the cycle after edge N+2 (2-cycle latency).
  - Back-to-back writes then produce back-to-back reg_wr pulses.
- Ordering: strictly FIFO. Writes to the same register are never merged.
- level updates on the edge after each push or pop.

Optional Feature:
- SPRITE_QUEUE_COALESCE_EN
  - Defined: a push whose cpu_addr equals the most recently pushed, still-queued entry overwrites that entry's data in place. No new entry is created and level is unchanged.
  - This applies only while that entry has not been popped and is not being popped in the same cycle. If it is being popped, the write is pushed normally.
  - Undefined: every accepted write occupies its own entry.

Test Plan:
- Vblank drain: v_valid=1; write (0x40,0x0123), (0x42,0x8005), (0x80,0x1000); reg_wr stays 0 and level=3. Drop v_valid to 0; exactly 3 reg_wr pulses in order with the same addr/data, then level=0.
- Immediate mode: immediate=1, v_valid=1; cpu_wr (0x44,0x0010) at edge N -> reg_wr=1 with reg_addr=0x44, reg_data=0x0010 after edge N+2.
- Overflow: v_valid=1, DEPTH=16. 17 writes -> cpu_ready=0 after the 16th, ovf=1 after the 17th, level=16. Then drain in vblank -> 16 pulses with the 17th data absent. Pulse ovf_clr -> ovf=0.
- Window close mid-drain: 10 queued, v_valid low for 4 cycles then high -> at most 5 pulses (one may already be registered when the window closes), remaining entries are held and level is correct. Next vblank drains the rest in order.
- Async reset mid-drain: assert rst_n=0 during DRAIN -> reg_wr=0 immediately, level=0, cpu_ready=1. After release, no stale pulses.
- Coalesce (macro defined): v_valid=1; write (0x40,0x0001) then (0x40,0x0002) -> level=1; vblank yields a single pulse with data 0x0002. Macro undefined -> level=2 and two pulses.

Source files
------------

// File: rtl/sprite_reg_queue.sv
// rtl/sprite_reg_queue.sv - sprite register write queue drained only in vertical blank
//
// Buffers CPU writes to sprite registers and releases them to the sprite
// engine only while the drain window is open (vertical blank, or always in
// immediate mode), so sprite state never changes mid-frame.
//
// Optional feature macro: SPRITE_QUEUE_COALESCE_EN
//   When defined, a write whose address matches the newest still-queued entry
//   overwrites that entry's data instead of taking a new slot.
//
// Ports:
//   clk_pixel  in   pixel clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   v_valid    in   high on visible lines, low in vertical blank
//   immediate  in   drain regardless of v_valid
//   cpu_wr     in   write strobe, one entry per high cycle
//   cpu_addr   in   [7:0]  sprite register byte address
//   cpu_data   in   [15:0] register data
//   cpu_ready  out  FIFO not full
//   ovf        out  sticky: a write was dropped
//   ovf_clr    in   clears ovf (a same-cycle drop wins)
//   level      out  [AW:0] FIFO occupancy 0..DEPTH
//   reg_wr     out  one-cycle pulse per drained entry
//   reg_addr   out  [7:0]  address of drained entry
//   reg_data   out  [15:0] data of drained entry

module sprite_reg_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          v_valid,
  input  logic          immediate,
  input  logic          cpu_wr,
  input  logic [7:0]    cpu_addr,
  input  logic [15:0]   cpu_data,
  output logic          cpu_ready,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [AW:0]   level,
  output logic          reg_wr,
  output logic [7:0]    reg_addr,
  output logic [15:0]   reg_data
);

  typedef enum logic {HOLD, DRAIN} state_e;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // Entry layout: {addr[7:0], data[15:0]}
  logic [23:0]   mem_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          v_valid_q;
  logic          reg_wr_q;
  logic [7:0]    reg_addr_q;
  logic [15:0]   reg_data_q;

  logic          full, empty, window, pop, push, drop, coalesce;

`ifdef SPRITE_QUEUE_COALESCE_EN
  logic [AW-1:0] last_ptr;
  assign last_ptr = wr_ptr_q - PTR_ONE;
`endif

  always_comb begin
    full   = (level_q == LVL_FULL);
    empty  = (level_q == '0);
    window = !v_valid_q || immediate;
    pop    = (state_q == DRAIN) && window && !empty;

`ifdef SPRITE_QUEUE_COALESCE_EN
    // The newest entry is still queued whenever the FIFO is non-empty; it is
    // leaving this cycle only if it is also the oldest one being popped.
    coalesce = cpu_wr && !empty && (mem_q[last_ptr][23:16] == cpu_addr)
               && !(pop && (level_q == LVL_ONE));
`else
    coalesce = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so a write at full is accepted.
    push = cpu_wr && !coalesce && (!full || pop);
    drop = cpu_wr && !coalesce && full && !pop;

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Leaving DRAIN on the post-update level keeps the empty-queue latency at
  // two cycles regardless of whether the engine was idle in HOLD or DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (window && !empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!window || (level_d == '0)) begin
          state_d = HOLD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      v_valid_q  <= 1'b1;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      v_valid_q <= v_valid;
      reg_wr_q  <= pop;
      if (pop) begin
        reg_addr_q <= mem_q[rd_ptr_q][23:16];
        reg_data_q <= mem_q[rd_ptr_q][15:0];
      end
    end
  end

  // Storage needs no reset: level and pointers define which slots are valid.
  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cpu_addr, cpu_data};
    end
`ifdef SPRITE_QUEUE_COALESCE_EN
    if (coalesce) begin
      mem_q[last_ptr][15:0] <= cpu_data;
    end
`endif
  end

  assign cpu_ready = (level_q != LVL_FULL);
  assign ovf       = ovf_q;
  assign level     = level_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_data  = reg_data_q;

endmodule

// File: tb/tb_sprite_reg_queue.sv
// tb/tb_sprite_reg_queue.sv - directed self-checking bench for sprite_reg_queue

module tb_sprite_reg_queue;

  logic        clk_pixel = 1'b0;
  logic        rst_n;
  logic        v_valid;
  logic        immediate;
  logic        cpu_wr;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ready;
  logic        ovf;
  logic        ovf_clr;
  logic [4:0]  level;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;

  int checks = 0;
  int errors = 0;

  logic [23:0] pq [$];

  sprite_reg_queue #(.DEPTH(16), .AW(4)) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .v_valid   (v_valid),
    .immediate (immediate),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_ready (cpu_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Capture every output pulse mid-cycle.
  always @(negedge clk_pixel) begin
    if (rst_n && reg_wr) pq.push_back({reg_addr, reg_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_pixel);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr   = 1'b1;
    tick(1);
    cpu_wr   = 1'b0;
  endtask

  initial begin
    logic [23:0] e;
    int n;

    rst_n = 1'b0; v_valid = 1'b1; immediate = 1'b0;
    cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0; ovf_clr = 1'b0;
    tick(3);
    check("rst_level", level, 0);
    check("rst_ready", cpu_ready, 1);
    check("rst_ovf", ovf, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_data", reg_data, 0);
    rst_n = 1'b1;
    tick(2);

    // Vblank drain
    wr(8'h40, 16'h0123);
    wr(8'h42, 16'h8005);
    wr(8'h80, 16'h1000);
    tick(4);
    check("vb_no_pulse", pq.size(), 0);
    check("vb_level3", level, 3);
    v_valid = 1'b0;
    tick(10);
    check("vb_count", pq.size(), 3);
    if (pq.size() == 3) begin
      check("vb_e0", pq[0], 24'h400123);
      check("vb_e1", pq[1], 24'h428005);
      check("vb_e2", pq[2], 24'h801000);
    end
    check("vb_level0", level, 0);
    v_valid = 1'b1;
    tick(3);
    pq.delete();

    // Immediate mode: two-cycle latency
    immediate = 1'b1;
    cpu_addr = 8'h44; cpu_data = 16'h0010; cpu_wr = 1'b1;
    tick(1);                               // edge N
    cpu_wr = 1'b0;
    check("imm_n0", reg_wr, 0);
    tick(1);                               // edge N+1
    check("imm_n1", reg_wr, 0);
    tick(1);                               // edge N+2
    check("imm_n2_wr", reg_wr, 1);
    check("imm_n2_addr", reg_addr, 8'h44);
    check("imm_n2_data", reg_data, 16'h0010);
    tick(1);
    check("imm_n3_wr", reg_wr, 0);
    immediate = 1'b0;
    tick(2);
    pq.delete();

    // Overflow
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 16'h0A00 + 16'(i));
    check("ovf_ready0", cpu_ready, 0);
    check("ovf_not_yet", ovf, 0);
    wr(8'hEE, 16'hDEAD);
    check("ovf_set", ovf, 1);
    check("ovf_level16", level, 16);
    v_valid = 1'b0;
    tick(24);
    check("ovf_count", pq.size(), 16);
    n = 0;
    for (int i = 0; i < 16 && i < pq.size(); i++) begin
      e = {8'h20 + 8'(i), 16'h0A00 + 16'(i)};
      if (pq[i] !== e) n++;
    end
    check("ovf_order", n, 0);
    check("ovf_sticky", ovf, 1);
    v_valid = 1'b1;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    tick(2);
    pq.delete();

    // Window closes mid-drain
    for (int i = 0; i < 10; i++) wr(8'h10 + 8'(i), 16'h0100 + 16'(i));
    v_valid = 1'b0;
    tick(4);
    v_valid = 1'b1;
    tick(4);
    check("wc_at_most5", (pq.size() <= 5), 1);
    check("wc_level", pq.size() + int'(level), 10);
    n = pq.size();
    tick(4);
    check("wc_held", pq.size(), n);
    v_valid = 1'b0;
    tick(20);
    check("wc_total", pq.size(), 10);
    n = 0;
    for (int i = 0; i < 10 && i < pq.size(); i++) begin
      e = {8'h10 + 8'(i), 16'h0100 + 16'(i)};
      if (pq[i] !== e) n++;
    end
    check("wc_order", n, 0);
    check("wc_level0", level, 0);
    v_valid = 1'b1;
    tick(3);
    pq.delete();

    // Async reset in the middle of a drain
    for (int i = 0; i < 8; i++) wr(8'h60 + 8'(i), 16'h0200 + 16'(i));
    v_valid = 1'b0;
    tick(4);
    check("ar_draining", reg_wr, 1);
    #2;
    rst_n = 1'b0;
    pq.delete();
    #1;
    check("ar_reg_wr", reg_wr, 0);
    check("ar_level", level, 0);
    check("ar_ready", cpu_ready, 1);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    check("ar_no_stale", pq.size(), 0);
    check("ar_level_after", level, 0);
    v_valid = 1'b1;
    tick(3);
    pq.delete();

    // Same-address writes
    wr(8'h40, 16'h0001);
    wr(8'h40, 16'h0002);
`ifdef SPRITE_QUEUE_COALESCE_EN
    check("co_level", level, 1);
`else
    check("co_level", level, 2);
`endif
    v_valid = 1'b0;
    tick(8);
`ifdef SPRITE_QUEUE_COALESCE_EN
    check("co_count", pq.size(), 1);
    if (pq.size() >= 1) check("co_e0", pq[0], 24'h400002);
`else
    check("co_count", pq.size(), 2);
    if (pq.size() >= 2) begin
      check("co_e0", pq[0], 24'h400001);
      check("co_e1", pq[1], 24'h400002);
    end
`endif
    check("co_level0", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
